// File: rtl/otp_nibble_collector.sv
// otp_nibble_collector: XORs an MSB-first nibble stream with a latched one-time-pad key into a ciphertext word.
// Optional OTP_CIPHER_PARITY_EN adds a registered parity output; MSG_SIZE defaults to 16.
`ifndef MSG_SIZE
`define MSG_SIZE 16
`endif
module otp_nibble_collector (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [`MSG_SIZE-1:0] key,
  input  logic [3:0]           nib_in,
  input  logic                 nib_valid,
  output logic                 busy,
  output logic                 done,
  output logic [`MSG_SIZE-1:0] cipher,
`ifdef OTP_CIPHER_PARITY_EN
  output logic                 parity,
`endif
  output logic [7:0]           nib_count
);
  localparam int W = `MSG_SIZE;
  localparam int N = W / 4;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, acc_n, key_reg, key_n, cipher_n;
  logic [7:0] cnt_n;
  logic [3:0] enc;
  assign enc  = nib_in ^ key_reg[W-1:W-4];
  assign busy = state == COLLECT;
  assign done = state == DONE;
  // start wins in every state: it both launches and aborts a message
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    key_n    = key_reg;
    cnt_n    = nib_count;
    cipher_n = cipher;
    if (start) begin
      state_n = COLLECT;
      key_n   = key;
      acc_n   = '0;
      cnt_n   = '0;
    end else if (state == COLLECT && nib_valid) begin
      acc_n = {acc[W-5:0], enc};
      key_n = {key_reg[W-5:0], 4'h0};
      cnt_n = nib_count + 8'd1;
      if (nib_count == 8'(N - 1)) begin
        cipher_n = {acc[W-5:0], enc};
        state_n  = DONE;
      end
    end else if (state == DONE) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      key_reg   <= '0;
      nib_count <= '0;
      cipher    <= '0;
`ifdef OTP_CIPHER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      key_reg   <= key_n;
      nib_count <= cnt_n;
      cipher    <= cipher_n;
`ifdef OTP_CIPHER_PARITY_EN
      parity    <= ^cipher_n;
`endif
    end
  end
endmodule

// File: tb/tb_otp_nibble_collector.sv
// tb_otp_nibble_collector: directed scenarios checked every cycle against a word-level pad model.
`ifndef MSG_SIZE
`define MSG_SIZE 16
`endif
module tb_otp_nibble_collector;
  localparam int W = `MSG_SIZE;
  localparam int N = W / 4;
  logic clk = 0, reset = 1, start = 0, nib_valid = 0;
  logic [W-1:0] key = '0;
  logic [3:0] nib_in = '0;
  logic busy, done;
  logic [W-1:0] cipher;
  logic [7:0] nib_count;
`ifdef OTP_CIPHER_PARITY_EN
  logic parity;
`endif
  int errors = 0, checks = 0, dcnt = 0;

  otp_nibble_collector dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .nib_in(nib_in),
    .nib_valid(nib_valid), .busy(busy), .done(done), .cipher(cipher),
`ifdef OTP_CIPHER_PARITY_EN
    .parity(parity),
`endif
    .nib_count(nib_count)
  );

  always #5 clk = ~clk;

  // model: ciphertext is simply key XOR the whole plaintext word once N nibbles arrive
  logic m_act = 0, m_done = 0;
  logic [W-1:0] m_key = '0, m_plain = '0, m_cipher = '0;
  int m_cnt = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0; m_done = 0; m_key = '0; m_plain = '0; m_cipher = '0; m_cnt = 0;
    end else begin
      logic was_done;
      was_done = m_done;
      m_done = 0;
      if (start) begin
        m_act = 1; m_key = key; m_plain = '0; m_cnt = 0;
      end else if (m_act && nib_valid) begin
        m_plain = (m_plain << 4) | W'(nib_in);
        m_cnt++;
        if (m_cnt == N) begin
          m_cipher = m_key ^ m_plain;
          m_act = 0;
          m_done = 1;
        end
      end else if (was_done) m_cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [1023:0] a, input logic [1023:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 1024'(busy), 1024'(m_act));
    chk("done", 1024'(done), 1024'(m_done));
    chk("cipher", 1024'(cipher), 1024'(m_cipher));
    chk("nib_count", 1024'(nib_count), 1024'(m_cnt));
`ifdef OTP_CIPHER_PARITY_EN
    chk("parity", 1024'(parity), 1024'(^m_cipher));
`endif
    if (done) dcnt++;
  end

  task automatic cyc(input logic s, input logic [W-1:0] k, input logic v, input logic [3:0] n);
    start = s; key = k; nib_valid = v; nib_in = n;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) cyc(0, '0, 0, 4'h0);
  endtask

  task automatic zero_now(input string nm);
    chk({nm, "_busy"}, 1024'(busy), 0);
    chk({nm, "_done"}, 1024'(done), 0);
    chk({nm, "_cipher"}, 1024'(cipher), 0);
    chk({nm, "_cnt"}, 1024'(nib_count), 0);
  endtask

  initial begin
    #1 zero_now("rst");
    @(posedge clk); #2;
    idle(1);
    reset = 0;
    idle(2);
    // back-to-back
    dcnt = 0;
    cyc(1, 16'hA5C3, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, '0, 1, 4'(i));
    chk("b2b_done_now", 1024'(done), 1);
    idle(2);
    chk("b2b_cipher", 1024'(cipher), 16'hB7F7);
    chk("b2b_pulses", 1024'(dcnt), 1);
`ifdef OTP_CIPHER_PARITY_EN
    chk("b2b_parity", 1024'(parity), 1);
`endif
    // stalled
    dcnt = 0;
    cyc(1, 16'hA5C3, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, '0, 1, 4'(i));
      if (i < 4) begin
        idle(2);
        chk("stall_busy", 1024'(busy), 1);
      end
    end
    idle(2);
    chk("stall_cipher", 1024'(cipher), 16'hB7F7);
    chk("stall_pulses", 1024'(dcnt), 1);
    // abort by restart
    dcnt = 0;
    cyc(1, 16'hA5C3, 0, 0);
    cyc(0, '0, 1, 4'h1);
    cyc(0, '0, 1, 4'h2);
    cyc(1, 16'h0000, 1, 4'h3);
    chk("abort_cnt", 1024'(nib_count), 0);
    cyc(0, '0, 1, 4'hF); cyc(0, '0, 1, 4'h0); cyc(0, '0, 1, 4'hF); cyc(0, '0, 1, 4'h0);
    idle(2);
    chk("abort_cipher", 1024'(cipher), 16'hF0F0);
    chk("abort_pulses", 1024'(dcnt), 1);
    // reset mid-message
    dcnt = 0;
    cyc(1, 16'hA5C3, 0, 0);
    for (int i = 1; i <= 3; i++) cyc(0, '0, 1, 4'(i));
    #1 reset = 1;
    #1 zero_now("midrst");
    reset = 0;
    cyc(0, '0, 1, 4'h4);
    idle(2);
    chk("midrst_pulses", 1024'(dcnt), 0);
    cyc(1, 16'hA5C3, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, '0, 1, 4'(i));
    idle(2);
    chk("midrst_cipher", 1024'(cipher), 16'hB7F7);
    chk("midrst_pulses2", 1024'(dcnt), 1);
    // nib_valid in idle, count sequence
    dcnt = 0;
    cyc(0, '0, 1, 4'h9); cyc(0, '0, 1, 4'h6);
    chk("idle_cnt", 1024'(nib_count), 0);
    cyc(1, 16'hFFFF, 0, 0);
    chk("seq_cnt0", 1024'(nib_count), 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, '0, 1, 4'h0);
      chk("seq_cnt", 1024'(nib_count), 1024'(i));
    end
    idle(2);
    chk("ones_cipher", 1024'(cipher), 16'hFFFF);
    chk("ones_pulses", 1024'(dcnt), 1);
    // start on the done cycle
    dcnt = 0;
    cyc(1, 16'hA5C3, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, '0, 1, 4'(i));
    chk("sod_done", 1024'(done), 1);
    cyc(1, 16'h0000, 0, 0);
    chk("sod_busy", 1024'(busy), 1);
    cyc(0, '0, 1, 4'hF); cyc(0, '0, 1, 4'h0);
    chk("sod_hold", 1024'(cipher), 16'hB7F7);
    cyc(0, '0, 1, 4'hF); cyc(0, '0, 1, 4'h0);
    idle(2);
    chk("sod_cipher", 1024'(cipher), 16'hF0F0);
    chk("sod_pulses", 1024'(dcnt), 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/otp_nibble_collector.md
OTP_NIBBLE_COLLECTOR -- requirements
Module: otp_nibble_collector

Interface
REQ-001 SHALL use compile-time define MSG_SIZE, default 16 (from constants.vh): message/key width in bits; multiple of 4, range 8..1020.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin a new message; samples key.
REQ-005 SHALL have port key  input  MSG_SIZE  one-time-pad key, MSB nibble pairs with first received nibble.
REQ-006 SHALL have port nib_in  input  4  plaintext nibble from the upstream shifter, MSB-first order.
REQ-007 SHALL have port nib_valid  input  1  nib_in is valid this cycle.
REQ-008 SHALL have port busy  output  1  high while collecting.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a full ciphertext is available.
REQ-010 SHALL have port cipher  output  MSG_SIZE  last completed ciphertext, held until next completion.
REQ-011 SHALL have port nib_count  output  8  nibbles accepted in the current message.

Function
REQ-012 SHALL implement FSM states IDLE, COLLECT, DONE; N = MSG_SIZE/4 nibbles per message.
REQ-013 IDLE + start: latch key into key_reg, clear accumulator and nib_count, go to COLLECT next cycle; busy=1 from that edge.
REQ-014 IDLE: nib_valid ignored; busy=0, done=0.
REQ-015 COLLECT + nib_valid: acc <= {acc[MSG_SIZE-5:0], nib_in ^ key_reg[MSG_SIZE-1:MSG_SIZE-4]}; key_reg shifts left 4 with zero fill; nib_count increments.
REQ-016 COLLECT without nib_valid: all state held (stalls allowed, any length).
REQ-017 COLLECT, nib_valid, nib_count == N-1: cipher <= final acc value (including this nibble) on the same edge; go to DONE; busy falls on that edge.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; nib_valid ignored in DONE.
REQ-019 start in COLLECT SHALL abort: key re-latched, acc and nib_count cleared, stay in COLLECT; cipher unchanged; start has priority over nib_valid.
REQ-020 start in DONE SHALL be accepted as in IDLE (done still pulses that cycle).
REQ-021 Latency: cipher valid and done high one cycle after the edge accepting the N-th nibble.
REQ-022 nib_count saturates never; it is cleared on start and resets to 0 on return to IDLE.

Reset
REQ-023 reset asserted SHALL immediately force state IDLE, busy=0, done=0, nib_count=0, cipher=0, acc=0, key_reg=0, regardless of clock.
REQ-024 reset mid-message SHALL discard the partial message; no done pulse follows.
REQ-025 First message after reset deassertion requires a fresh start.

Configuration
REQ-026 Macro OTP_CIPHER_PARITY_EN SHALL, when defined, add output parity (1 bit): XOR of all cipher bits, registered with cipher, reset 0.
REQ-027 Without OTP_CIPHER_PARITY_EN, port parity and its logic SHALL be absent; all other behaviour identical.

Verification (MSG_SIZE=16)
REQ-028 reset, start with key=0xA5C3, nibbles 1,2,3,4 back-to-back -> cipher=0xB7F7, done one cycle after 4th nibble, parity=1 if enabled.
REQ-029 same key/nibbles with 2 idle cycles between each nibble -> cipher=0xB7F7, busy high throughout, done single pulse.
REQ-030 start, 2 nibbles, then start with key=0x0000 and nibbles F,0,F,0 -> cipher=0xF0F0, exactly one done pulse.
REQ-031 start, 3 nibbles, reset asserted between edges -> outputs zero immediately, no done; new message then completes correctly.
REQ-032 nib_valid pulses in IDLE then start, 4 nibbles 0 with key=0xFFFF -> cipher=0xFFFF, nib_count 0..4 sequence observed.
REQ-033 start held high on the DONE cycle -> done pulses, new message starts, prior cipher held until next completion.
